// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronizes the RX pin, samples each bit at its centre and
// hands completed bytes to a valid/ready consumer, flagging framing errors and overruns.
module uart_rx_core #(
  parameter int unsigned CLOCK_RATE = 24000000,
  parameter int unsigned BAUD_RATE  = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       in,
  input  logic       ready,
  output logic [7:0] out,
  output logic       valid,
  output logic       error,
  output logic       overrun
);

  localparam int unsigned DIV  = CLOCK_RATE / BAUD_RATE;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e          r_state, w_state_next;
  logic            r_sync1, r_sync2;
  logic [CW-1:0]   r_baud, w_baud_next;
  logic [2:0]      r_bit_idx, w_bit_idx_next;
  logic [7:0]      r_shift, w_shift_next;
  logic [7:0]      r_out, w_out_next;
  logic            r_valid, w_valid_next;
  logic            r_error, w_error_next;
  logic            r_overrun, w_overrun_next;
  logic            w_rx_s, w_tick, w_frame_ok, w_frame_bad, w_xfer;

  assign w_rx_s = r_sync2;
  // START waits half a bit to land on the start-bit centre; every other state waits a full bit.
  assign w_tick = (r_state == StStart) ? (r_baud == HALF_LAST) : (r_baud == BAUD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (!enable) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle:  if (!w_rx_s) w_state_next = StStart;
        StStart: if (w_tick) w_state_next = w_rx_s ? StIdle : StData;
        StData:  if (w_tick && (r_bit_idx == 3'd7)) w_state_next = StStop;
        StStop:  if (w_tick) w_state_next = w_rx_s ? StIdle : StBreak;
        StBreak: if (w_rx_s) w_state_next = StIdle;
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_comb begin
    w_frame_ok  = enable && (r_state == StStop) && w_tick && w_rx_s;
    w_frame_bad = enable && (r_state == StStop) && w_tick && !w_rx_s;
    w_xfer      = r_valid && ready;

    w_baud_next = '0;
    if ((r_state == StStart || r_state == StData || r_state == StStop) &&
        (w_state_next == r_state) && !w_tick) begin
      w_baud_next = r_baud + 1'b1;
    end

    w_bit_idx_next = '0;
    w_shift_next   = r_shift;
    if (r_state == StData && enable) begin
      w_bit_idx_next = r_bit_idx;
      if (w_tick) begin
        w_shift_next[r_bit_idx] = w_rx_s;
        w_bit_idx_next = (r_bit_idx == 3'd7) ? 3'd0 : r_bit_idx + 3'd1;
      end
    end

    w_out_next     = w_frame_ok ? r_shift : r_out;
    w_error_next   = w_frame_bad;
    w_valid_next   = r_valid;
    w_overrun_next = r_overrun;
    if (w_frame_ok) begin
      w_valid_next = 1'b1;
      // A transfer in the completion cycle consumes the old byte, so it is not an overrun.
      w_overrun_next = w_xfer ? 1'b0 : (r_valid ? 1'b1 : r_overrun);
    end else if (w_xfer) begin
      w_valid_next   = 1'b0;
      w_overrun_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_out     <= '0;
      r_valid   <= 1'b0;
      r_error   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_sync1   <= in;
      r_sync2   <= r_sync1;
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_out     <= w_out_next;
      r_valid   <= w_valid_next;
      r_error   <= w_error_next;
      r_overrun <= w_overrun_next;
    end
  end

  assign out     = r_out;
  assign valid   = r_valid;
  assign error   = r_error;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: vector table, hand-built corner cases and
// randomized frames checked against a frame-level model of the byte handshake.
module tb_uart_rx_core;

  localparam int unsigned CLK_RATE = 24000000;
  localparam int unsigned BAUD     = 115200;
  localparam int unsigned DIV      = CLK_RATE / BAUD;
  localparam int unsigned HALF     = DIV / 2;

  logic       clk = 1'b0;
  logic       reset, enable, in, ready;
  logic [7:0] out;
  logic       valid, error, overrun;

  always #5 clk = ~clk;

  uart_rx_core #(
    .CLOCK_RATE(CLK_RATE),
    .BAUD_RATE (BAUD)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .in     (in),
    .ready  (ready),
    .out    (out),
    .valid  (valid),
    .error  (error),
    .overrun(overrun)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor of handshake events and error pulses.
  int unsigned rise_cnt = 0, last_rise = 0, err_cnt = 0, vhigh_cnt = 0;
  logic        prev_valid = 1'b0;
  logic [7:0]  xfer_q[$];
  always @(negedge clk) begin
    if (valid && !prev_valid) begin
      rise_cnt  <= rise_cnt + 1;
      last_rise <= cyc;
    end
    if (valid) vhigh_cnt <= vhigh_cnt + 1;
    if (error) err_cnt <= err_cnt + 1;
    if (valid && ready) xfer_q.push_back(out);
    prev_valid <= valid;
  end

  int tests = 0, fails = 0;
  int unsigned start_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pops one transferred byte (or reports none) and compares it.
  task automatic check_xfer(input string name, input logic [7:0] exp);
    tests++;
    if (xfer_q.size() == 0) begin
      fails++;
      $display("FAIL %s: no byte transferred, expected %0h", name, exp);
    end else begin
      logic [7:0] got;
      got = xfer_q.pop_front();
      if (got !== exp) begin
        fails++;
        $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
    end
  endtask

  function automatic logic [9:0] mkf(input logic [7:0] d, input logic s);
    return {s, d, 1'b0};
  endfunction

  // Drives line bits f[from..to-1], each for DIV cycles.
  task automatic drive_seq(input logic [9:0] f, input int from, input int to);
    for (int i = from; i < to; i++) begin
      @(posedge clk);
      #1 in = f[i];
      if (i == 0) start_cyc = cyc;
      repeat (DIV - 1) @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1 in = 1'b1;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] d, input logic s);
    drive_seq(mkf(d, s), 0, 10);
    idle(DIV);
  endtask

  task automatic pulse_ready();
    @(posedge clk);
    #1 ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_byte;
    int         exp_err;
  } vec_t;

  vec_t        vecs[5];
  int unsigned r0, e0, v0, lat;
  logic [9:0]  fr;
  logic [7:0]  m_out;
  logic        m_valid, m_ovr;
  logic [7:0]  m_q[$];

  initial begin
    reset = 1'b1; enable = 1'b1; in = 1'b1; ready = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("rst_out", out, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    #1 reset = 1'b0;
    idle(10);

    // Vector table: ready held high, one frame each.
    vecs[0] = '{8'h30, 1'b1, 1'b1, 0};
    vecs[1] = '{8'h20, 1'b1, 1'b1, 0};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 0};
    vecs[4] = '{8'h5A, 1'b0, 1'b0, 1};
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      r0 = rise_cnt; e0 = err_cnt;
      send(vecs[i].data, vecs[i].stop);
      check($sformatf("tbl%0d_rise", i), rise_cnt - r0, {31'd0, vecs[i].exp_byte});
      check($sformatf("tbl%0d_err", i), err_cnt - e0, vecs[i].exp_err);
      check($sformatf("tbl%0d_nxfer", i), xfer_q.size(), {31'd0, vecs[i].exp_byte});
      if (xfer_q.size() != 0) check_xfer($sformatf("tbl%0d_data", i), vecs[i].data);
    end

    // 0x30 with ready high: latency, one-cycle valid.
    r0 = rise_cnt; v0 = vhigh_cnt; e0 = err_cnt;
    send(8'h30, 1'b1);
    lat = last_rise - start_cyc;
    tests++;
    if (lat < 1977 || lat > 1979) begin
      fails++;
      $display("FAIL t1_latency: got %0d, expected 1977..1979", lat);
    end
    check("t1_rise", rise_cnt - r0, 1);
    check("t1_vhigh", vhigh_cnt - v0, 1);
    check("t1_err", err_cnt - e0, 0);
    check("t1_ovr", overrun, 1'b0);
    check_xfer("t1_data", 8'h30);

    // Back-to-back 0x31, 0x20 with ready low: overrun.
    ready = 1'b0;
    drive_seq(mkf(8'h31, 1'b1), 0, 10);
    drive_seq(mkf(8'h20, 1'b1), 0, 10);
    idle(DIV);
    check("t2_valid", valid, 1'b1);
    check("t2_out", out, 8'h20);
    check("t2_ovr", overrun, 1'b1);
    @(posedge clk);
    #1 ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 ready = 1'b0;
    check("t2_nxfer", xfer_q.size(), 1);
    check_xfer("t2_data", 8'h20);
    check("t2_ovr_clr", overrun, 1'b0);
    check("t2_valid_clr", valid, 1'b0);

    // Framing error followed by a held-low break.
    ready = 1'b1;
    r0 = rise_cnt; e0 = err_cnt;
    drive_seq(mkf(8'h55, 1'b0), 0, 10);
    repeat (3 * DIV) @(posedge clk);
    idle(DIV);
    check("t3_err", err_cnt - e0, 1);
    check("t3_rise", rise_cnt - r0, 0);
    check("t3_valid", valid, 1'b0);
    send(8'h31, 1'b1);
    check_xfer("t3_next", 8'h31);

    // Transfer and frame completion in the same cycle.
    ready = 1'b0;
    send(8'h3C, 1'b1);
    fork
      drive_seq(mkf(8'hC3, 1'b1), 0, 10);
      begin
        @(posedge clk);
        repeat (1978) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    idle(DIV);
    check("tsc_nxfer", xfer_q.size(), 1);
    check_xfer("tsc_old", 8'h3C);
    check("tsc_valid", valid, 1'b1);
    check("tsc_out", out, 8'hC3);
    check("tsc_ovr", overrun, 1'b0);
    pulse_ready();
    check_xfer("tsc_new", 8'hC3);

    // Glitch shorter than half a bit.
    r0 = rise_cnt; e0 = err_cnt;
    @(posedge clk);
    #1 in = 1'b0;
    repeat (50) @(posedge clk);
    idle(2 * DIV);
    check("t4_rise", rise_cnt - r0, 0);
    check("t4_err", err_cnt - e0, 0);

    // Reset during data bit 4 of 0xA5 with a byte pending.
    ready = 1'b0;
    send(8'h3C, 1'b1);
    fr = mkf(8'hA5, 1'b1);
    drive_seq(fr, 0, 5);
    @(posedge clk);
    #1 in = fr[5];
    repeat (HALF) @(posedge clk);
    #1 reset = 1'b1;
    #2;
    check("t5_out", out, 8'h00);
    check("t5_valid", valid, 1'b0);
    check("t5_error", error, 1'b0);
    check("t5_ovr", overrun, 1'b0);
    in = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    idle(DIV);
    ready = 1'b1;
    send(8'hA5, 1'b1);
    check("t5_nxfer", xfer_q.size(), 1);
    check_xfer("t5_data", 8'hA5);

    // Enable dropped during data bit 2; rest of the frame sent while disabled.
    r0 = rise_cnt; e0 = err_cnt;
    fr = mkf(8'h6B, 1'b1);
    drive_seq(fr, 0, 3);
    @(posedge clk);
    #1 in = fr[3];
    repeat (HALF) @(posedge clk);
    #1 enable = 1'b0;
    repeat (HALF - 1) @(posedge clk);
    drive_seq(fr, 4, 10);
    idle(DIV);
    enable = 1'b1;
    idle(DIV);
    check("t6_rise", rise_cnt - r0, 0);
    check("t6_err", err_cnt - e0, 0);
    send(8'h31, 1'b1);
    check_xfer("t6_next", 8'h31);

    // Randomized frames against a frame-level handshake model.
    m_valid = 1'b0; m_ovr = 1'b0; m_out = 8'h00;
    for (int k = 0; k < 12; k++) begin
      logic [7:0] d;
      logic       s;
      int         mode;
      d = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 5) != 0);
      mode = $urandom_range(0, 2);
      e0 = err_cnt;
      @(posedge clk);
      #1 ready = (mode == 0);
      if (mode == 0 && m_valid) begin
        m_q.push_back(m_out);
        m_valid = 1'b0;
        m_ovr = 1'b0;
      end
      send(d, s);
      if (s) begin
        if (mode == 0) begin
          m_q.push_back(d);
        end else begin
          if (m_valid) m_ovr = 1'b1;
          m_out = d;
          m_valid = 1'b1;
        end
      end
      if (mode == 1) begin
        pulse_ready();
        if (m_valid) begin
          m_q.push_back(m_out);
          m_valid = 1'b0;
          m_ovr = 1'b0;
        end
      end
      check($sformatf("rnd%0d_err", k), err_cnt - e0, s ? 0 : 1);
      check($sformatf("rnd%0d_valid", k), valid, m_valid);
      check($sformatf("rnd%0d_ovr", k), overrun, m_ovr);
      if (m_valid) check($sformatf("rnd%0d_out", k), out, m_out);
      check($sformatf("rnd%0d_nxfer", k), xfer_q.size(), m_q.size());
      while (m_q.size() != 0 && xfer_q.size() != 0) begin
        logic [7:0] e;
        e = m_q.pop_front();
        check_xfer($sformatf("rnd%0d_data", k), e);
      end
      m_q.delete();
      xfer_q.delete();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
